mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage of the 5-stage LoongArch pipeline. It sits between exe_stage and wb_stage.
//  - Receives the ES bundle. Waits for the data-SRAM data_ok of the load/store that ES issued.
//  - Aligns and extends load data, and selects the mul/div results.
//  - Forwards results to ID and passes the bundle on to WB.
//  - Tracks in-flight SRAM requests, so responses to requests killed by an exception or ertn are dropped.
// PARAMETERS
//  OUTST_W  2  width of the outstanding-request and discard counters (max 3 in flight)
// PORTS
//  clk                clk     1    clock; the only clock
//  reset              in      1    synchronous, active-high
//  ws_allowin         in      1    WB can accept
//  ms_allowin         out     1    MS can accept
//  es_to_ms_valid     in      1    ES bundle valid
//  es_to_ms_bus       in      `ES_TO_MS_BUS_WD    ES bundle
//  es_mul_res_bus     in      65   {sel_hi, prod[63:0]}
//  es_div_res_bus     in      64   {rem[31:0], quo[31:0]}
//  data_sram_req      in      1    monitored ES request
//  data_sram_addr_ok  in      1    monitored address handshake
//  data_sram_data_ok  in      1    read/write response
//  data_sram_rdata    in      32   read data
//  ms_to_ws_valid     out     1    bundle to WB valid
//  ms_to_ws_bus       out     `MS_TO_WS_BUS_WD    bundle to WB
//  ms_fwd_blk_bus     out     `MS_FWD_BLK_BUS_WD  {we, blk, dest[4:0], result[31:0]}
//  ms_to_es_ls_cancel out     1    cancels younger ES memory ops
//  ms_csr_blk_bus     out     `MS_CSR_BLK_BUS_WD  {csr_we, ertn, csr_wnum[13:0]}
//  wb_exc, wb_ertn    in      1    flush request from WB
// BEHAVIOUR
//  Reset values: ms_valid=0, bus_r=0, outst=0, discard=0, rdata_buf_v=0.
//   Hence ms_to_ws_valid=0, ls_cancel=0, and all blk/fwd valid bits are 0.
//  Pipeline handshake:
//   - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
//   - On ms_allowin, ms_valid <= es_to_ms_valid. bus_r loads only when es_to_ms_valid & ms_allowin.
//  Memory wait:
//   - need_dok = ms_valid & (|load_op | mem_we) & ~ls_cancel_flag (the ES-side cancel bit in the bundle).
//   - ms_ready_go = ~need_dok | rdata_buf_v | (data_sram_data_ok & discard==0).
//  Response buffer:
//   - If data_ok is accepted (discard==0) while need_dok and !ws_allowin, latch rdata and set rdata_buf_v.
//   - Clear rdata_buf_v when the bundle moves to WB.
//   - Load data = rdata_buf_v ? buf : data_sram_rdata.
//  Outstanding counter:
//   - +1 on data_sram_req & addr_ok; -1 on data_ok. Both in the same cycle: no change.
//   - Saturates at 2^OUTST_W-1; the bench must assert that saturation is never reached.
//  Flush (wb_exc | wb_ertn):
//   - ms_valid <= 0.
//   - discard <= outst + (req&addr_ok) - (data_ok & discard==0) - (MS request already answered).
//   - While discard>0, each data_ok decrements discard and is not delivered.
//   - A flush in the same cycle as es_to_ms_valid does not load ES (ES already gates its valid).
//  Load extension (load_op is one-hot {ld.b, ld.h, ld.w, ld.bu, ld.hu}):
//   - Byte lane = addr[1:0]; half lane = addr[1].
//   - ld.b/ld.h sign-extend; ld.bu/ld.hu zero-extend.
//  Result select, in priority order:
//   1. load -> extended data.
//   2. mul  -> sel_hi ? prod[63:32] : prod[31:0].
//   3. div  -> div_res_sel ? rem : quo.
//   4. else -> ES result.
//  Forward bus:
//   - we  = gr_we & ms_valid.
//   - blk = ms_valid & load & ~ms_ready_go.
//  ls_cancel: ms_to_es_ls_cancel = ms_valid & (|exc_flgs | ertn), combinational.
//  csr_blk: csr_we/ertn are ANDed with ms_valid.
//  Reset mid-transaction: all counters clear. The SRAM is reset in the same cycle, so no stale data_ok arrives.
// STRUCTURE
//  mycpu.h holds:
//   - bus widths: `ES_TO_MS_BUS_WD, `MS_TO_WS_BUS_WD, `MS_FWD_BLK_BUS_WD, `MS_CSR_BLK_BUS_WD;
//   - LD_* one-hot bit indices;
//   - `EXC_NUM and the EXC_FLG_* indices.
//  Sub-module load_align (combinational): {load_op, addr[1:0], rdata} -> 32-bit result.
//  Counters, buffer and handshake stay in mem_stage.
// TESTING
//  1. ld.b addr=0x..3, rdata=0x80FF_FF7F, data_ok 2 cycles after entry -> result 0xFFFFFF80, ms_ready_go rises in the data_ok cycle.
//  2. ld.hu addr=0x..2, rdata=0xBEEF_1234, ws_allowin=0 for 3 cycles -> buffer holds the data; on release WB gets 0x0000BEEF once.
//  3. Two loads accepted by SRAM, then wb_exc before either data_ok -> discard=2; both data_ok dropped; ms_to_ws_valid stays 0.
//  4. mul with sel_hi=1, prod=0x0000_0001_FFFF_FFFE -> result 0x00000001; div_res_sel=1, {rem=7, quo=3} -> result 7.
//  5. MS holds an ALE-flagged st.w, ES holds a ld.w -> ms_to_es_ls_cancel=1, ES issues no req, outst unchanged.
//  6. Reset asserted while outst=1 and discard=1 -> next cycle all counters 0; ms_allowin=1; no ms_to_ws_valid.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Bundle layouts, bus widths and one-hot indices shared by the memory stage
// and its neighbours.
package mem_stage_pkg;

    localparam int EXC_NUM      = 6;
    localparam int EXC_FLG_INT  = 0;
    localparam int EXC_FLG_ADEF = 1;
    localparam int EXC_FLG_SYS  = 2;
    localparam int EXC_FLG_BRK  = 3;
    localparam int EXC_FLG_INE  = 4;
    localparam int EXC_FLG_ALE  = 5;

    // load_op is {ld.b, ld.h, ld.w, ld.bu, ld.hu}
    localparam int LD_B  = 4;
    localparam int LD_H  = 3;
    localparam int LD_W  = 2;
    localparam int LD_BU = 1;
    localparam int LD_HU = 0;

    typedef struct packed {
        logic [31:0]        pc;
        logic               gr_we;
        logic [4:0]         dest;
        logic [31:0]        result;
        logic [4:0]         load_op;
        logic               mem_we;
        logic               mul_op;
        logic               div_op;
        logic               div_res_sel;
        logic               ls_cancel;
        logic [EXC_NUM-1:0] exc_flgs;
        logic               ertn;
        logic               csr_we;
        logic [13:0]        csr_wnum;
    } es_to_ms_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic               gr_we;
        logic [4:0]         dest;
        logic [31:0]        result;
        logic [EXC_NUM-1:0] exc_flgs;
        logic               ertn;
        logic               csr_we;
        logic [13:0]        csr_wnum;
    } ms_to_ws_t;

    typedef struct packed {
        logic        we;
        logic        blk;
        logic [4:0]  dest;
        logic [31:0] result;
    } ms_fwd_blk_t;

    typedef struct packed {
        logic        csr_we;
        logic        ertn;
        logic [13:0] csr_wnum;
    } ms_csr_blk_t;

    localparam int ES_TO_MS_BUS_WD   = $bits(es_to_ms_t);
    localparam int MS_TO_WS_BUS_WD   = $bits(ms_to_ws_t);
    localparam int MS_FWD_BLK_BUS_WD = $bits(ms_fwd_blk_t);
    localparam int MS_CSR_BLK_BUS_WD = $bits(ms_csr_blk_t);

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half of a load response and extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  load_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        unique case (addr)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
        endcase
    end

    assign lane_h = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        unique case (1'b1)
            load_op[LD_B]:  result = {{24{lane_b[7]}}, lane_b};
            load_op[LD_H]:  result = {{16{lane_h[15]}}, lane_h};
            load_op[LD_BU]: result = {24'd0, lane_b};
            load_op[LD_HU]: result = {16'd0, lane_h};
            default:        result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: waits for the data-SRAM response, shapes the result and
// drops responses that belong to requests killed by a flush.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int OUTST_W = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ws_allowin,
    output logic                         ms_allowin,
    input  logic                         es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
    input  logic [64:0]                  es_mul_res_bus,
    input  logic [63:0]                  es_div_res_bus,
    input  logic                         data_sram_req,
    input  logic                         data_sram_addr_ok,
    input  logic                         data_sram_data_ok,
    input  logic [31:0]                  data_sram_rdata,
    output logic                         ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
    output logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus,
    output logic                         ms_to_es_ls_cancel,
    output logic [MS_CSR_BLK_BUS_WD-1:0] ms_csr_blk_bus,
    input  logic                         wb_exc,
    input  logic                         wb_ertn
);

    localparam logic [OUTST_W-1:0] CNT_MAX = '1;
    localparam logic [OUTST_W-1:0] CNT_ONE = OUTST_W'(1);

    es_to_ms_t          bus_r;
    ms_to_ws_t          ws_bus;
    ms_fwd_blk_t        fwd_bus;
    ms_csr_blk_t        csr_bus;
    logic               ms_valid;
    logic               ms_ready_go;
    logic               is_load;
    logic               need_dok;
    logic               dok_take;
    logic               flush;
    logic               req_acc;
    logic               rdata_buf_v;
    logic [31:0]        rdata_buf;
    logic [31:0]        load_data;
    logic [31:0]        load_res;
    logic [31:0]        ms_result;
    logic [OUTST_W-1:0] outst;
    logic [OUTST_W-1:0] outst_nx;
    logic [OUTST_W-1:0] discard;

    assign flush       = wb_exc | wb_ertn;
    assign req_acc     = data_sram_req & data_sram_addr_ok;
    assign dok_take    = data_sram_data_ok & (discard == '0);
    assign is_load     = |bus_r.load_op;
    assign need_dok    = ms_valid & (is_load | bus_r.mem_we) & ~bus_r.ls_cancel;
    assign ms_ready_go = ~need_dok | rdata_buf_v | dok_take;
    assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;
    assign load_data   = rdata_buf_v ? rdata_buf : data_sram_rdata;

    load_align u_load_align (
        .load_op (bus_r.load_op),
        .addr    (bus_r.result[1:0]),
        .rdata   (load_data),
        .result  (load_res)
    );

    always_comb begin
        if (is_load)
            ms_result = load_res;
        else if (bus_r.mul_op)
            ms_result = es_mul_res_bus[64] ? es_mul_res_bus[63:32]
                                           : es_mul_res_bus[31:0];
        else if (bus_r.div_op)
            ms_result = bus_r.div_res_sel ? es_div_res_bus[63:32]
                                          : es_div_res_bus[31:0];
        else
            ms_result = bus_r.result;
    end

    // Every response ever requested is counted, including ones to discard.
    always_comb begin
        outst_nx = outst;
        if (req_acc && !data_sram_data_ok && outst != CNT_MAX)
            outst_nx = outst + CNT_ONE;
        else if (!req_acc && data_sram_data_ok && outst != '0)
            outst_nx = outst - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid    <= 1'b0;
            bus_r       <= '0;
            outst       <= '0;
            discard     <= '0;
            rdata_buf_v <= 1'b0;
            rdata_buf   <= '0;
        end else begin
            outst <= outst_nx;
            if (flush) begin
                ms_valid    <= 1'b0;
                discard     <= outst_nx;
                rdata_buf_v <= 1'b0;
            end else begin
                if (data_sram_data_ok && discard != '0)
                    discard <= discard - CNT_ONE;
                if (ms_allowin)
                    ms_valid <= es_to_ms_valid;
                if (es_to_ms_valid && ms_allowin)
                    bus_r <= es_to_ms_bus;
                if (ms_to_ws_valid && ws_allowin) begin
                    rdata_buf_v <= 1'b0;
                end else if (need_dok && dok_take && !rdata_buf_v) begin
                    rdata_buf_v <= 1'b1;
                    rdata_buf   <= data_sram_rdata;
                end
            end
        end
    end

    always_comb begin
        ws_bus.pc       = bus_r.pc;
        ws_bus.gr_we    = bus_r.gr_we;
        ws_bus.dest     = bus_r.dest;
        ws_bus.result   = ms_result;
        ws_bus.exc_flgs = bus_r.exc_flgs;
        ws_bus.ertn     = bus_r.ertn;
        ws_bus.csr_we   = bus_r.csr_we;
        ws_bus.csr_wnum = bus_r.csr_wnum;
        fwd_bus.we      = bus_r.gr_we & ms_valid;
        fwd_bus.blk     = ms_valid & is_load & ~ms_ready_go;
        fwd_bus.dest    = bus_r.dest;
        fwd_bus.result  = ms_result;
        csr_bus.csr_we  = bus_r.csr_we & ms_valid;
        csr_bus.ertn    = bus_r.ertn & ms_valid;
        csr_bus.csr_wnum = bus_r.csr_wnum;
    end

    assign ms_to_ws_bus       = ws_bus;
    assign ms_fwd_blk_bus     = fwd_bus;
    assign ms_csr_blk_bus     = csr_bus;
    assign ms_to_es_ls_cancel = ms_valid & ((|bus_r.exc_flgs) | bus_r.ertn);

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a transaction-level
// model of the SRAM response stream and result shaping.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         reset;
    logic                         ws_allowin;
    logic                         ms_allowin;
    logic                         es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus;
    logic [64:0]                  es_mul_res_bus;
    logic [63:0]                  es_div_res_bus;
    logic                         data_sram_req;
    logic                         data_sram_addr_ok;
    logic                         data_sram_data_ok;
    logic [31:0]                  data_sram_rdata;
    logic                         ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus;
    logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus;
    logic                         ms_to_es_ls_cancel;
    logic [MS_CSR_BLK_BUS_WD-1:0] ms_csr_blk_bus;
    logic                         wb_exc;
    logic                         wb_ertn;

    es_to_ms_t   es_b;
    ms_to_ws_t   ws_o;
    ms_fwd_blk_t fwd_o;
    ms_csr_blk_t csr_o;

    assign es_to_ms_bus = es_b;
    assign ws_o  = ms_to_ws_bus;
    assign fwd_o = ms_fwd_blk_bus;
    assign csr_o = ms_csr_blk_bus;

    mem_stage #(.OUTST_W(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .ws_allowin         (ws_allowin),
        .ms_allowin         (ms_allowin),
        .es_to_ms_valid     (es_to_ms_valid),
        .es_to_ms_bus       (es_to_ms_bus),
        .es_mul_res_bus     (es_mul_res_bus),
        .es_div_res_bus     (es_div_res_bus),
        .data_sram_req      (data_sram_req),
        .data_sram_addr_ok  (data_sram_addr_ok),
        .data_sram_data_ok  (data_sram_data_ok),
        .data_sram_rdata    (data_sram_rdata),
        .ms_to_ws_valid     (ms_to_ws_valid),
        .ms_to_ws_bus       (ms_to_ws_bus),
        .ms_fwd_blk_bus     (ms_fwd_blk_bus),
        .ms_to_es_ls_cancel (ms_to_es_ls_cancel),
        .ms_csr_blk_bus     (ms_csr_blk_bus),
        .wb_exc             (wb_exc),
        .wb_ertn            (wb_ertn)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // SRAM response stream: in-order, each entry live or killed by a flush
    int unsigned pend_due[$];
    logic [31:0] pend_data[$];
    bit          pend_live[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid    = 1'b0;
        data_sram_req     = 1'b0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        wb_exc            = 1'b0;
        wb_ertn           = 1'b0;
        ws_allowin        = 1'b1;
    endtask

    task automatic issue(input es_to_ms_t b, input bit req);
        es_b              = b;
        es_to_ms_valid    = 1'b1;
        data_sram_req     = req;
        data_sram_addr_ok = req;
        #1;
        chk("issue_allowin", ms_allowin, 1);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_req     = 1'b0;
        data_sram_addr_ok = 1'b0;
    endtask

    function automatic logic [31:0] ld_ext(input logic [4:0] op,
                                           input logic [1:0] a,
                                           input logic [31:0] d);
        logic [31:0] w;
        logic [31:0] hw;
        logic [31:0] r;
        w  = d >> (8 * a);
        hw = d >> (16 * a[1]);
        r  = d;
        if (op[LD_B])  r = int'($signed(w[7:0]));
        if (op[LD_H])  r = int'($signed(hw[15:0]));
        if (op[LD_BU]) r = w & 32'h0000_00FF;
        if (op[LD_HU]) r = hw & 32'h0000_FFFF;
        return r;
    endfunction

    function automatic logic [31:0] exp_res(input es_to_ms_t b,
                                            input logic [64:0] m,
                                            input logic [63:0] d,
                                            input logic [31:0] rd);
        if (b.load_op != 5'd0) return ld_ext(b.load_op, b.result[1:0], rd);
        if (b.mul_op) return m[64] ? m[63:32] : m[31:0];
        if (b.div_op) return b.div_res_sel ? d[63:32] : d[31:0];
        return b.result;
    endfunction

    // kind 0..4 loads, 5 store, 6 mul, 7 div, 8 alu
    function automatic es_to_ms_t rand_bundle(input int kind);
        es_to_ms_t b;
        b        = '0;
        b.pc     = $urandom;
        b.dest   = 5'($urandom);
        b.result = $urandom;
        b.gr_we  = (kind != 5);
        if (kind <= 4) b.load_op = 5'd1 << kind;
        if (kind == 5) b.mem_we = 1'b1;
        if (kind == 6) b.mul_op = 1'b1;
        if (kind == 7) begin
            b.div_op      = 1'b1;
            b.div_res_sel = 1'($urandom);
        end
        return b;
    endfunction

    function automatic int n_dead();
        int n = 0;
        foreach (pend_live[i]) if (!pend_live[i]) n++;
        return n;
    endfunction

    task automatic sram_drive();
        if (pend_due.size() > 0 && cyc >= int'(pend_due[0])) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = pend_data[0];
        end else begin
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
        end
    endtask

    task automatic sram_post();
        if (data_sram_data_ok) begin
            void'(pend_due.pop_front());
            void'(pend_data.pop_front());
            void'(pend_live.pop_front());
        end
        cyc++;
    endtask

    task automatic chk_cnt();
        chk("outst", dut.outst, pend_due.size());
        chk("discard", dut.discard, n_dead());
        chk("outst_unsat", dut.outst != 2'b11, 1);
    endtask

    initial begin
        es_to_ms_t   b;
        int          nxfer;
        int          k;
        bit          mem;
        bit          got;
        bit          done;
        bit          head_live;
        bit          exp_v;
        bit          fire;
        logic [31:0] got_data;

        reset           = 1'b1;
        es_b            = '0;
        es_mul_res_bus  = '0;
        es_div_res_bus  = '0;
        data_sram_rdata = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_ws_valid", ms_to_ws_valid, 0);
        chk("rst_allowin", ms_allowin, 1);
        chk("rst_ls_cancel", ms_to_es_ls_cancel, 0);
        chk("rst_fwd_we", fwd_o.we, 0);
        chk("rst_fwd_blk", fwd_o.blk, 0);
        chk("rst_csr", {csr_o.csr_we, csr_o.ertn}, 0);
        chk("rst_outst", dut.outst, 0);

        // ld.b from byte 3, response two cycles after entry
        b = '0;
        b.load_op[LD_B] = 1'b1;
        b.result = 32'h1000_0003;
        b.gr_we = 1'b1;
        b.dest = 5'd5;
        issue(b, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("t1_wait_valid", ms_to_ws_valid, 0);
            chk("t1_wait_blk", fwd_o.blk, 1);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF_FF7F;
        #1;
        chk("t1_valid", ms_to_ws_valid, 1);
        chk("t1_result", ws_o.result, 32'hFFFF_FF80);
        chk("t1_blk", fwd_o.blk, 0);
        chk("t1_fwd", {fwd_o.we, fwd_o.dest, fwd_o.result}, {1'b1, 5'd5, 32'hFFFF_FF80});
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("t1_drained", ms_to_ws_valid, 0);
        chk("t1_outst", dut.outst, 0);

        // ld.hu held by WB back-pressure
        b = '0;
        b.load_op[LD_HU] = 1'b1;
        b.result = 32'h2000_0002;
        b.gr_we = 1'b1;
        ws_allowin = 1'b0;
        issue(b, 1'b1);
        nxfer = 0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hBEEF_1234;
        for (int c = 0; c < 4; c++) begin
            ws_allowin = (c == 3);
            #1;
            chk("t2_valid", ms_to_ws_valid, 1);
            chk("t2_result", ws_o.result, 32'h0000_BEEF);
            if (ms_to_ws_valid && ws_allowin) nxfer++;
            tick();
            data_sram_data_ok = 1'b0;
            data_sram_rdata = 32'hDEAD_DEAD;
        end
        #1;
        chk("t2_after", ms_to_ws_valid, 0);
        chk("t2_once", nxfer, 1);

        // two accepted loads, then a flush before either response
        b = '0;
        b.load_op[LD_W] = 1'b1;
        b.gr_we = 1'b1;
        issue(b, 1'b1);
        es_to_ms_valid = 1'b1;
        data_sram_req = 1'b1;
        data_sram_addr_ok = 1'b1;
        #1;
        chk("t3_stall", ms_allowin, 0);
        tick();
        idle();
        wb_exc = 1'b1;
        tick();
        wb_exc = 1'b0;
        #1;
        chk("t3_discard", dut.discard, 2);
        chk("t3_allowin", ms_allowin, 1);
        for (int c = 0; c < 2; c++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata = $urandom;
            #1;
            chk("t3_dropped", ms_to_ws_valid, 0);
            tick();
        end
        data_sram_data_ok = 1'b0;
        #1;
        chk("t3_cnt", {dut.outst, dut.discard}, 0);

        // mul / div / alu result selection
        b = '0;
        b.mul_op = 1'b1;
        b.gr_we = 1'b1;
        b.result = 32'h1234_5678;
        es_mul_res_bus = {1'b1, 64'h0000_0001_FFFF_FFFE};
        ws_allowin = 1'b0;
        issue(b, 1'b0);
        #1;
        chk("t4_mul_hi", ws_o.result, 32'h0000_0001);
        es_mul_res_bus[64] = 1'b0;
        #1;
        chk("t4_mul_lo", ws_o.result, 32'hFFFF_FFFE);
        ws_allowin = 1'b1;
        tick();
        b.mul_op = 1'b0;
        b.div_op = 1'b1;
        b.div_res_sel = 1'b1;
        es_div_res_bus = {32'd7, 32'd3};
        ws_allowin = 1'b0;
        issue(b, 1'b0);
        #1;
        chk("t4_div_rem", ws_o.result, 32'd7);
        ws_allowin = 1'b1;
        tick();
        b.div_op = 1'b0;
        issue(b, 1'b0);
        #1;
        chk("t4_alu", ws_o.result, 32'h1234_5678);
        tick();

        // ALE-flagged store in MS cancels the younger load in ES
        b = '0;
        b.mem_we = 1'b1;
        b.ls_cancel = 1'b1;
        b.exc_flgs[EXC_FLG_ALE] = 1'b1;
        ws_allowin = 1'b0;
        issue(b, 1'b0);
        b = '0;
        b.load_op[LD_W] = 1'b1;
        es_b = b;
        es_to_ms_valid = 1'b1;
        #1;
        chk("t5_cancel", ms_to_es_ls_cancel, 1);
        chk("t5_ready", ms_to_ws_valid, 1);
        chk("t5_hold", ms_allowin, 0);
        tick();
        chk("t5_outst", dut.outst, 0);
        es_to_ms_valid = 1'b0;
        ws_allowin = 1'b1;
        tick();
        #1;
        chk("t5_clear", ms_to_es_ls_cancel, 0);
        b = '0;
        b.ertn = 1'b1;
        b.csr_we = 1'b1;
        b.csr_wnum = 14'h0006;
        ws_allowin = 1'b0;
        issue(b, 1'b0);
        #1;
        chk("t5_csr", csr_o, {1'b1, 1'b1, 14'h0006});
        chk("t5_ertn_cancel", ms_to_es_ls_cancel, 1);
        ws_allowin = 1'b1;
        tick();

        // reset while one response is still owed and marked for discard
        b = '0;
        b.load_op[LD_W] = 1'b1;
        issue(b, 1'b1);
        es_to_ms_valid = 1'b1;
        data_sram_req = 1'b1;
        data_sram_addr_ok = 1'b1;
        tick();
        idle();
        wb_exc = 1'b1;
        tick();
        idle();
        data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        chk("t6_pre", {dut.outst, dut.discard}, {2'd1, 2'd1});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t6_cnt", {dut.outst, dut.discard}, 0);
        chk("t6_allowin", ms_allowin, 1);
        chk("t6_valid", ms_to_ws_valid, 0);
        b.gr_we = 1'b1;
        issue(b, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("t6_deliver", {ms_to_ws_valid, ws_o.result}, {1'b1, 32'hCAFE_F00D});
        tick();
        idle();

        // randomized instruction stream with random latency, stalls, flushes
        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 8);
            b = rand_bundle(k);
            mem = (k <= 5);
            es_mul_res_bus = {1'($urandom), $urandom, $urandom};
            es_div_res_bus = {$urandom, $urandom};
            sram_drive();
            if (mem) begin
                pend_due.push_back(cyc + 1 + $urandom_range(0, 3));
                pend_data.push_back($urandom);
                pend_live.push_back(1'b1);
            end
            ws_allowin = 1'($urandom);
            issue(b, mem);
            sram_post();
            chk_cnt();
            es_b = rand_bundle($urandom_range(0, 8));
            got = 1'b0;
            done = 1'b0;
            got_data = '0;
            for (int c = 0; c < 40 && !done; c++) begin
                sram_drive();
                ws_allowin = 1'($urandom);
                head_live = data_sram_data_ok && pend_live[0];
                if (mem && !got && !head_live && pend_due.size() == 1 &&
                    $urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 1) == 0) wb_exc = 1'b1;
                    else wb_ertn = 1'b1;
                    #1;
                    chk("rnd_flush_valid", ms_to_ws_valid, 0);
                    tick();
                    sram_post();
                    foreach (pend_live[j]) pend_live[j] = 1'b0;
                    wb_exc = 1'b0;
                    wb_ertn = 1'b0;
                    done = 1'b1;
                end else begin
                    #1;
                    if (head_live) got_data = data_sram_rdata;
                    exp_v = !mem || got || head_live;
                    chk("rnd_valid", ms_to_ws_valid, exp_v);
                    if (exp_v)
                        chk("rnd_result", ws_o.result,
                            exp_res(b, es_mul_res_bus, es_div_res_bus, got_data));
                    chk("rnd_blk", fwd_o.blk, (b.load_op != 5'd0) && !exp_v);
                    chk("rnd_we", fwd_o.we, b.gr_we);
                    fire = exp_v && ws_allowin;
                    tick();
                    sram_post();
                    if (head_live) got = 1'b1;
                    if (fire) done = 1'b1;
                end
                chk_cnt();
            end
            chk("rnd_timeout", done, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
